// File: rtl/finalsoc_key_ctrl_pkg.sv
// Shared constants for the push-button controller: register map and
// debounce threshold width.
package finalsoc_key_ctrl_pkg;

    localparam int THRESH_W = 16;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_THRESH  = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

endpackage

// File: rtl/finalsoc_key_debounce.sv
// Single-key debouncer: two-flop synchronizer, mismatch counter and the
// debounced stable flop. Emits a one-cycle press pulse on the same edge
// that stable falls from 1 (released) to 0 (pressed).
module finalsoc_key_debounce
    import finalsoc_key_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_key,
    input  logic [THRESH_W-1:0] i_thresh,
    output logic                o_stable,
    output logic                o_press
);

    logic                r_sync1;
    logic                r_sync2;
    logic                r_stable;
    logic [THRESH_W-1:0] r_cnt;

    logic                w_mismatch;
    logic [THRESH_W:0]   w_cnt_inc;
    logic                w_hit;

    // Compare one bit wider so a count sitting at the top of the range can
    // never wrap and miss the threshold; thresholds 0 and 1 hit on the
    // first mismatch, giving a plain one-cycle delay.
    assign w_mismatch = (r_sync2 != r_stable);
    assign w_cnt_inc  = {1'b0, r_cnt} + {{THRESH_W{1'b0}}, 1'b1};
    assign w_hit      = w_mismatch && (w_cnt_inc >= {1'b0, i_thresh});

    // Synchronize the raw key, count consecutive mismatches, flip stable at threshold.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge (synchronous), so it sits
        // inside the clocked block rather than in the sensitivity list.
        if (!reset_n) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_stable <= 1'b1;
            r_cnt    <= '0;
        end else begin
            // NOTE: non-blocking assignments let r_sync2 pick up the old
            // r_sync1, forming a true two-stage shift.
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
            if (!w_mismatch) begin
                r_cnt <= '0;
            end else if (w_hit) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= w_cnt_inc[THRESH_W-1:0];
            end
        end
    end

    assign o_stable = r_stable;
    // A hit while stable is 1 can only be a move to 0, i.e. a press.
    assign o_press  = w_hit && r_stable;

endmodule

// File: rtl/finalsoc_key_ctrl.sv
// Avalon-MM push-button controller: per-key debounce, press-edge capture
// with write-1-to-clear, interrupt masking and a registered read port.
module finalsoc_key_ctrl
    import finalsoc_key_ctrl_pkg::*;
#(
    parameter int                  WIDTH            = 2,
    parameter logic [THRESH_W-1:0] DEBOUNCE_DEFAULT = 16'd50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [THRESH_W-1:0] r_thresh;
    logic [WIDTH-1:0]    r_irqmask;
    logic [WIDTH-1:0]    r_edgecap;
    logic [31:0]         r_readdata;
    logic                r_irq;

    logic [WIDTH-1:0]    w_stable;
    logic [WIDTH-1:0]    w_press;
    logic                w_wr;
    logic [WIDTH-1:0]    w_clr;
    logic [31:0]         w_rdata;
    logic                w_unused;

    // One debouncer per key.
    for (genvar g = 0; g < WIDTH; g++) begin : g_key
        finalsoc_key_debounce u_debounce (
            .clk      (clk),
            .reset_n  (reset_n),
            .i_key    (in_port[g]),
            .i_thresh (r_thresh),
            .o_stable (w_stable[g]),
            .o_press  (w_press[g])
        );
    end

    assign w_wr  = chipselect && !write_n;
    assign w_clr = (w_wr && (address == ADDR_EDGECAP)) ? writedata[WIDTH-1:0] : '0;

    // Upper write-data bits have no register behind them.
    assign w_unused = ^writedata[31:THRESH_W];

    // Read mux over the current register values, zero-extended.
    always_comb begin
        // NOTE: default first so every path assigns w_rdata and no latch forms.
        w_rdata = '0;
        case (address)
            ADDR_DATA:    w_rdata[WIDTH-1:0]    = w_stable;
            ADDR_THRESH:  w_rdata[THRESH_W-1:0] = r_thresh;
            ADDR_IRQMASK: w_rdata[WIDTH-1:0]    = r_irqmask;
            ADDR_EDGECAP: w_rdata[WIDTH-1:0]    = r_edgecap;
            default:      w_rdata               = '0;
        endcase
    end

    // Register file, edge capture, registered irq and registered read data.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_thresh   <= DEBOUNCE_DEFAULT;
            r_irqmask  <= '0;
            r_edgecap  <= '0;
            r_readdata <= '0;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr && (address == ADDR_THRESH))  r_thresh  <= writedata[THRESH_W-1:0];
            if (w_wr && (address == ADDR_IRQMASK)) r_irqmask <= writedata[WIDTH-1:0];
            // Press OR-ed in after the clear so a coincident event survives.
            r_edgecap  <= (r_edgecap & ~w_clr) | w_press;
            r_irq      <= |(r_edgecap & r_irqmask);
            r_readdata <= w_rdata;
        end
    end

    assign readdata = r_readdata;
    assign irq      = r_irq;

endmodule

// File: tb/tb_finalsoc_key_ctrl.sv
// Directed bench for finalsoc_key_ctrl: inputs driven and outputs sampled
// on the falling clock edge, expected values worked out by hand.
module tb_finalsoc_key_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [1:0]  in_port;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    finalsoc_key_ctrl #(.WIDTH(2), .DEBOUNCE_DEFAULT(16'd50000)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives a write from the current falling edge across one rising edge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        @(negedge clk);
        check(tag, readdata, exp);
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 2'b11;
        step(3);
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;

        // Register values after reset.
        rd("post_rst_data",    2'd0, 32'h3);
        rd("post_rst_thresh",  2'd1, 32'hC350);
        rd("post_rst_irqmask", 2'd2, 32'h0);
        rd("post_rst_edgecap", 2'd3, 32'h0);
        check("post_rst_irq", {31'b0, irq}, 32'h0);

        // THRESH=4 press on key0: stable flips on the 6th edge, read on the 7th.
        wr(2'd1, 32'h4);
        rd("thresh_4", 2'd1, 32'h4);
        address    = 2'd0;
        in_port[0] = 1'b0;
        step(6);
        check("press_data_not_yet", readdata, 32'h3);
        step(1);
        check("press_data_at7", readdata, 32'h2);
        rd("press_edgecap", 2'd3, 32'h1);
        check("press_irq_masked", {31'b0, irq}, 32'h0);
        in_port[0] = 1'b1;
        step(10);
        rd("release_data", 2'd0, 32'h3);
        rd("release_no_edge", 2'd3, 32'h1);
        wr(2'd3, 32'h1);
        rd("w1c_clear", 2'd3, 32'h0);

        // Three-cycle glitch on key1 stays below THRESH=4.
        in_port[1] = 1'b0;
        step(3);
        in_port[1] = 1'b1;
        step(10);
        rd("glitch_data", 2'd0, 32'h3);
        rd("glitch_edgecap", 2'd3, 32'h0);

        // Interrupt raise and clear-to-drop latency.
        wr(2'd2, 32'h1);
        in_port[0] = 1'b0;
        step(10);
        check("irq_raised", {31'b0, irq}, 32'h1);
        wr(2'd3, 32'h1);
        check("irq_one_after_clr", {31'b0, irq}, 32'h1);
        step(1);
        check("irq_two_after_clr", {31'b0, irq}, 32'h0);
        in_port[0] = 1'b1;
        step(10);
        rd("irq_release_no_edge", 2'd3, 32'h0);
        check("irq_after_release", {31'b0, irq}, 32'h0);

        // Unmasking an already-captured edge raises irq one cycle later.
        in_port[1] = 1'b0;
        step(10);
        rd("key1_edge_masked", 2'd3, 32'h2);
        check("key1_irq_masked", {31'b0, irq}, 32'h0);
        wr(2'd2, 32'h3);
        check("unmask_irq_not_yet", {31'b0, irq}, 32'h0);
        step(1);
        check("unmask_irq_raised", {31'b0, irq}, 32'h1);
        rd("irqmask_rd", 2'd2, 32'h3);
        in_port[1] = 1'b1;
        step(10);
        wr(2'd3, 32'h3);
        wr(2'd2, 32'hFFFF_FFFC);
        rd("irqmask_upper_ignored", 2'd2, 32'h0);
        step(1);
        check("irq_cleared", {31'b0, irq}, 32'h0);

        // THRESH=1: press event coincides with a clearing write; event wins.
        wr(2'd1, 32'h1);
        in_port[0] = 1'b0;
        step(2);
        wr(2'd3, 32'h1);
        rd("coincide_edgecap", 2'd3, 32'h1);
        rd("coincide_data", 2'd0, 32'h2);
        in_port[0] = 1'b1;
        step(5);
        wr(2'd3, 32'h1);
        rd("coincide_cleared", 2'd3, 32'h0);

        // THRESH=8: reset at count 5 with key0 held; count restarts from scratch.
        wr(2'd1, 32'h8);
        in_port[0] = 1'b0;
        step(7);
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        check("midrst_readdata", readdata, 32'h0);
        check("midrst_irq", {31'b0, irq}, 32'h0);
        wr(2'd1, 32'h8);
        address = 2'd3;
        for (int i = 0; i < 9; i++) begin
            step(1);
            check($sformatf("midrst_edgecap_low_%0d", i), readdata, 32'h0);
        end
        step(1);
        check("midrst_edgecap_set", readdata, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard bound on run time.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
